// File: rtl/mod_param_scheduler.sv
// Access scheduler for the parameter router: round-robin processor cache windows with settle/guard cycles.
// Optional macro PARAM_SCHED_USER_LIMIT_EN bounds a user grant while a processor start is pending.
module mod_param_scheduler #(
    parameter int CRIT_TIMEOUT = 255,
    parameter int USER_MAX     = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       proce_Start,
    input  logic       proce_Done,
    input  logic       user_Req,
    output logic       user_Gnt,
    output logic [1:0] sel,
    output logic       critical,
    output logic       proce_Busy,
    output logic       timeout,
    output logic [7:0] pass_Count
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_USER    = 3'd1,
        ST_ARM     = 3'd2,
        ST_CRIT    = 3'd3,
        ST_RELEASE = 3'd4
    } state_t;

    localparam logic [7:0] CRIT_LAST = 8'(CRIT_TIMEOUT - 1);

    state_t     state_r;
    state_t     next_state_s;
    logic [7:0] crit_cnt_r;
    logic       crit_hit_s;
    logic       user_expire_s;
    logic       gnt_nxt_s;
    logic       crit_nxt_s;
    logic       timeout_nxt_s;
    logic [1:0] sel_nxt_s;
    logic [7:0] pass_nxt_s;

    assign crit_hit_s = (crit_cnt_r == CRIT_LAST);

`ifdef PARAM_SCHED_USER_LIMIT_EN
    localparam logic [7:0] USER_LAST = 8'(USER_MAX - 1);
    logic [7:0] user_cnt_r;

    // Counts USER cycles with a pending processor start; idle outside USER so it is clear on entry
    always_ff @(posedge clk) begin
        if (rst) begin
            user_cnt_r <= 8'd0;
        end else if (state_r != ST_USER) begin
            user_cnt_r <= 8'd0;
        end else if (proce_Start && (user_cnt_r != USER_LAST)) begin
            user_cnt_r <= user_cnt_r + 8'd1;
        end else begin
            user_cnt_r <= user_cnt_r;
        end
    end

    assign user_expire_s = (state_r == ST_USER) && proce_Start && (user_cnt_r == USER_LAST);
`else
    logic [7:0] unused_user_max_s;
    assign unused_user_max_s = 8'(USER_MAX);
    assign user_expire_s     = 1'b0;
`endif

    // State register and critical-window counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            crit_cnt_r <= 8'd0;
        end else begin
            state_r <= next_state_s;
            if (state_r == ST_ARM) begin
                crit_cnt_r <= 8'd0;
            end else if (state_r == ST_CRIT) begin
                crit_cnt_r <= crit_cnt_r + 8'd1;
            end else begin
                crit_cnt_r <= crit_cnt_r;
            end
        end
    end

    // Next-state decode; processor wins a tie in IDLE
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (proce_Start) begin
                    next_state_s = ST_ARM;
                end else if (user_Req) begin
                    next_state_s = ST_USER;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_USER: begin
                if (!user_Req || user_expire_s) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_USER;
                end
            end
            ST_ARM:  next_state_s = ST_CRIT;
            ST_CRIT: begin
                if (proce_Done || crit_hit_s) begin
                    next_state_s = ST_RELEASE;
                end else begin
                    next_state_s = ST_CRIT;
                end
            end
            ST_RELEASE: next_state_s = ST_IDLE;
            default:    next_state_s = ST_IDLE;
        endcase
    end

    // Output decode from the upcoming state so every output is a flop
    always_comb begin
        gnt_nxt_s     = (next_state_s == ST_USER);
        crit_nxt_s    = (next_state_s == ST_CRIT);
        timeout_nxt_s = (state_r == ST_CRIT) && !proce_Done && crit_hit_s;
        sel_nxt_s     = sel;
        pass_nxt_s    = pass_Count;
        if (state_r == ST_RELEASE) begin
            sel_nxt_s = sel + 2'd1;
            if (sel == 2'd3) begin
                pass_nxt_s = pass_Count + 8'd1;
            end else begin
                pass_nxt_s = pass_Count;
            end
        end else begin
            sel_nxt_s  = sel;
            pass_nxt_s = pass_Count;
        end
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            user_Gnt   <= 1'b0;
            sel        <= 2'd0;
            critical   <= 1'b0;
            proce_Busy <= 1'b0;
            timeout    <= 1'b0;
            pass_Count <= 8'd0;
        end else begin
            user_Gnt   <= gnt_nxt_s;
            sel        <= sel_nxt_s;
            critical   <= crit_nxt_s;
            proce_Busy <= crit_nxt_s;
            timeout    <= timeout_nxt_s;
            pass_Count <= pass_nxt_s;
        end
    end

endmodule

// File: tb/tb_mod_param_scheduler.sv
// Self-checking bench for mod_param_scheduler: vector table for reset/round-robin/user grant,
// hand sequences for timeout, arbitration, user limit and reset in mid-window.
module tb_mod_param_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       proce_Start;
    logic       proce_Done;
    logic       user_Req;
    logic       user_Gnt;
    logic [1:0] sel;
    logic       critical;
    logic       proce_Busy;
    logic       timeout;
    logic [7:0] pass_Count;

    int n_checks = 0;
    int n_fail   = 0;

    mod_param_scheduler #(.CRIT_TIMEOUT(8), .USER_MAX(4)) dut (
        .clk(clk), .rst(rst), .proce_Start(proce_Start), .proce_Done(proce_Done),
        .user_Req(user_Req), .user_Gnt(user_Gnt), .sel(sel), .critical(critical),
        .proce_Busy(proce_Busy), .timeout(timeout), .pass_Count(pass_Count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       start;
        logic       done;
        logic       req;
        logic       gnt;
        logic [1:0] sel;
        logic       crit;
        logic       to;
        logic [7:0] pass;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic s, input logic d, input logic q,
                                input logic g, input logic [1:0] sl, input logic c,
                                input logic t, input logic [7:0] p);
        vec_t v;
        v.rst = r; v.start = s; v.done = d; v.req = q;
        v.gnt = g; v.sel = sl; v.crit = c; v.to = t; v.pass = p;
        vecs.push_back(v);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    int exp_sel  = 0;
    int exp_pass = 0;

    // One complete processor window with done on the first CRIT cycle
    task automatic do_window();
        proce_Start = 1'b1; tick();
        proce_Start = 1'b0; tick();
        check("window_crit", int'(critical), 1);
        proce_Done = 1'b1; tick();
        proce_Done = 1'b0; tick();
        if (exp_sel == 3) exp_pass++;
        exp_sel = (exp_sel + 1) % 4;
        check("window_sel", int'(sel), exp_sel);
        check("window_pass", int'(pass_Count), exp_pass);
    endtask

    initial begin
        int crit_cycles;
        int to_cycles;
        int cyc;
        logic [13:0] act_p;
        logic [13:0] exp_p;

        rst = 1'b1; proce_Start = 1'b0; proce_Done = 1'b0; user_Req = 1'b0;

        // reset, then a stray done in IDLE
        add(1, 0, 0, 0,  0, 2'd0, 0, 0, 8'd0);
        add(1, 0, 0, 0,  0, 2'd0, 0, 0, 8'd0);
        add(0, 0, 1, 0,  0, 2'd0, 0, 0, 8'd0);
        add(0, 0, 0, 0,  0, 2'd0, 0, 0, 8'd0);
        // round robin: start, 3 CRIT cycles, done, release -> new sel
        for (int w = 0; w < 4; w++) begin
            add(0, 1, 0, 0,  0, 2'(w), 0, 0, 8'd0);
            add(0, 0, 0, 0,  0, 2'(w), 1, 0, 8'd0);
            add(0, 0, 0, 0,  0, 2'(w), 1, 0, 8'd0);
            add(0, 0, 0, 0,  0, 2'(w), 1, 0, 8'd0);
            add(0, 0, 1, 0,  0, 2'(w), 0, 0, 8'd0);
            add(0, 0, 0, 0,  0, 2'(w + 1), 0, 0, (w == 3) ? 8'd1 : 8'd0);
        end
        // user grant follows request; done ignored in USER
        add(0, 0, 0, 1,  1, 2'd0, 0, 0, 8'd1);
        add(0, 0, 1, 1,  1, 2'd0, 0, 0, 8'd1);
        add(0, 0, 0, 0,  0, 2'd0, 0, 0, 8'd1);

        foreach (vecs[i]) begin
            rst = vecs[i].rst; proce_Start = vecs[i].start;
            proce_Done = vecs[i].done; user_Req = vecs[i].req;
            tick();
            act_p = {user_Gnt, sel, critical, proce_Busy, timeout, pass_Count};
            exp_p = {vecs[i].gnt, vecs[i].sel, vecs[i].crit, vecs[i].crit, vecs[i].to, vecs[i].pass};
            check($sformatf("vec%0d", i), int'(act_p), int'(exp_p));
        end
        proce_Done = 1'b0; user_Req = 1'b0;
        exp_sel = 0; exp_pass = 1;

        // timeout: no done, CRIT held exactly 8 cycles, single pulse while critical is low
        proce_Start = 1'b1; tick();
        proce_Start = 1'b0;
        crit_cycles = 0; to_cycles = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (critical) crit_cycles++;
            if (timeout && !critical) to_cycles++;
            if (timeout && critical) to_cycles += 100;
        end
        exp_sel = 1;
        check("to_crit_len", crit_cycles, 8);
        check("to_pulses", to_cycles, 1);
        check("to_sel", int'(sel), exp_sel);

        // done on the 8th critical cycle wins over the timeout
        proce_Start = 1'b1; tick();
        proce_Start = 1'b0;
        crit_cycles = 0; to_cycles = 0;
        for (int i = 0; i < 12; i++) begin
            proce_Done = (critical && crit_cycles == 8);
            tick();
            if (critical) crit_cycles++;
            if (timeout) to_cycles++;
        end
        proce_Done = 1'b0;
        exp_sel = 2;
        check("done8_crit_len", crit_cycles, 8);
        check("done8_pulses", to_cycles, 0);
        check("done8_sel", int'(sel), exp_sel);

        // arbitration: simultaneous start and request, processor first
        user_Req = 1'b1; proce_Start = 1'b1; tick();
        check("arb_arm", int'({user_Gnt, critical}), 0);
        proce_Start = 1'b0; tick();
        check("arb_crit", int'({user_Gnt, critical}), 1);
        proce_Done = 1'b1; tick();
        check("arb_release", int'({user_Gnt, critical}), 0);
        proce_Done = 1'b0; tick();
        exp_sel = 3;
        check("arb_idle", int'({user_Gnt, critical, sel}), exp_sel);
        tick();
        check("arb_user", int'({user_Gnt, critical}), 2);
        user_Req = 1'b0; tick();
        check("arb_user_off", int'(user_Gnt), 0);

        // user grant while a processor start is pending
        user_Req = 1'b1; tick();
        check("ulim_gnt", int'(user_Gnt), 1);
        proce_Start = 1'b1;
`ifdef PARAM_SCHED_USER_LIMIT_EN
        cyc = 0;
        while (user_Gnt && cyc < 20) begin tick(); cyc++; end
        check("ulim_drop", cyc, 4);
        cyc = 0;
        while (!critical && cyc < 20) begin tick(); cyc++; end
        check("ulim_crit", cyc, 2);
        proce_Start = 1'b0; user_Req = 1'b0; proce_Done = 1'b1; tick();
        proce_Done = 1'b0; tick();
        exp_sel = 0; exp_pass = 2;
        check("ulim_sel", int'(sel), exp_sel);
`else
        cyc = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (user_Gnt && !critical) cyc++;
        end
        check("ulim_hold", cyc, 10);
        proce_Start = 1'b0; tick();
        user_Req = 1'b0; tick();
        check("ulim_release", int'(user_Gnt), 0);
`endif

        // walk to sel=2 through full windows
        for (int i = 0; i < 4 && exp_sel != 2; i++) do_window();
        check("pre_rst_sel", int'(sel), 2);

        // reset in the middle of a CRIT window
        proce_Start = 1'b1; tick();
        proce_Start = 1'b0; tick();
        tick();
        check("mid_crit", int'({critical, sel}), 6);
        rst = 1'b1; tick();
        check("mid_rst", int'({user_Gnt, sel, critical, proce_Busy, timeout, pass_Count}), 0);
        rst = 1'b0;
        to_cycles = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (timeout || critical) to_cycles++;
        end
        check("post_rst_quiet", to_cycles, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mod_param_scheduler.md
# mod_param_scheduler

Access scheduler that drives the `sel` / `critical` control pair of the parameter router. It decides when the processor owns a parameter cache and when the user port is granted access. It steps the processor through caches 0→1→2→3 round-robin, with a settle cycle around every critical window so the router never switches `sel` while `critical` is high. It sits between the processor/user request logic and the parameter router.

## Interface
Parameters:
- `CRIT_TIMEOUT`, default 255: maximum cycles in a critical window before forced release (1..255).
- `USER_MAX`, default 16: user grant cycle limit while a processor start is pending. Used only with `PARAM_SCHED_USER_LIMIT_EN`.

Ports. One clock; reset is synchronous and active-high.
- `clk` in 1: system clock, rising edge.
- `rst` in 1: synchronous reset, active-high.
- `proce_Start` in 1: processor requests its next cache window (level; sampled in IDLE).
- `proce_Done` in 1: processor finished with the current cache (sampled in CRIT).
- `user_Req` in 1: user requests cache access (level).
- `user_Gnt` out 1: user access granted.
- `sel` out 2: cache index to the router.
- `critical` out 1: processor owns cache `sel` (to the router).
- `proce_Busy` out 1: processor window open (equals `critical`).
- `timeout` out 1: one-cycle pulse on a forced release.
- `pass_Count` out 8: count of completed rounds (`sel` wrapping 3→0); wraps 255→0.

## Operation
- All outputs are registered. Reset values: `sel`=0, `critical`=0, `proce_Busy`=0, `user_Gnt`=0, `timeout`=0, `pass_Count`=0. State resets to IDLE and the timeout counter to 0.
- **IDLE**: `critical`=0, `user_Gnt`=0.
  - `proce_Start` → ARM. The processor has priority when both requests are present.
  - `user_Req` alone → USER.
- **USER**: `user_Gnt`=1. When `user_Req` is 0 → IDLE. A pending `proce_Start` does not preempt the user; see Configuration for the exception.
- **ARM**: one settle cycle.
  - `critical`=0; `sel` is already stable.
  - Timeout counter cleared to 0.
  - Unconditional transition → CRIT.
- **CRIT**: `critical`=1, `proce_Busy`=1; counter increments each cycle.
  - `proce_Done` → RELEASE.
  - Else, counter == `CRIT_TIMEOUT`-1 → RELEASE with `timeout` pulsed for one cycle.
  - If `proce_Done` and the timeout hit in the same cycle, done wins and no pulse is issued.
- **RELEASE**: one guard cycle.
  - `critical`=0.
  - `sel` ← `sel`+1 mod 4 takes effect on exit, so the new `sel` appears together with IDLE.
  - When `sel` goes 3→0, `pass_Count` increments.
  - Unconditional transition → IDLE.
- `sel` changes only on the RELEASE→IDLE edge. `critical` is never 1 in the cycle in which `sel` changes.
- `user_Gnt` and `critical` are never both 1.
- `proce_Done` outside CRIT is ignored. `proce_Start` outside IDLE is held pending by the requester (level) and is not latched.
- Reset asserted in any state returns everything to reset values on the next edge. `critical` drops with no RELEASE cycle and `sel` returns to 0.

## Timing
- Processor start to window open: `proce_Start` sampled high in IDLE at edge N gives ARM after N and `critical`=1 after edge N+1. Latency is 2 cycles.
- Window close: `proce_Done` sampled at edge M gives `critical`=0 after M. The new `sel` and IDLE appear after M+1, and the next ARM is possible at M+2.
- Minimum processor cycle is 4 edges (IDLE, ARM, CRIT, RELEASE).
- Timeout: CRIT is held for exactly `CRIT_TIMEOUT` cycles, then RELEASE with `timeout`=1 for that single cycle.
- User grant:
  - `user_Req` high in IDLE at edge N gives `user_Gnt`=1 after N.
  - `user_Req` low at edge K gives `user_Gnt`=0 after K.

## Configuration
- `PARAM_SCHED_USER_LIMIT_EN` defined: in USER, a cycle counter runs while `proce_Start` is 1.
  - When it reaches `USER_MAX`, the state goes to IDLE with `user_Gnt`=0 even if `user_Req` is still 1.
  - The next edge then goes to ARM, because the processor has priority.
  - The counter clears on entry to USER.
- Not defined: the user holds the grant until `user_Req` drops, and `USER_MAX` is unused.

## Test plan
- Reset then idle: after `rst` for 2 cycles, expect `sel`=0, `critical`=0, `user_Gnt`=0, `pass_Count`=0. Pulse `proce_Done` → no change.
- Round robin: 4× (`proce_Start` 1 cycle, `proce_Done` 3 cycles after `critical` rises).
  - `sel` sequence must be 0,1,2,3,0 and `pass_Count` must end at 1.
  - Check `critical` rises 2 cycles after each start and `sel` is stable while `critical`=1.
- Timeout: `CRIT_TIMEOUT`=8, start with no done → `critical` high exactly 8 cycles, `timeout` one-cycle pulse, then `sel`=1.
  - Repeat with `proce_Done` on cycle 8 → no pulse.
- Arbitration: `user_Req` and `proce_Start` rise in the same IDLE cycle → ARM wins, `user_Gnt` stays 0 until RELEASE→IDLE, then `user_Gnt`=1 one cycle later.
- User limit (`PARAM_SCHED_USER_LIMIT_EN`, `USER_MAX`=4): user granted, `proce_Start` held high → `user_Gnt` drops after 4 cycles and `critical` rises 2 cycles later.
  - Without the macro, the grant persists until `user_Req`=0.
- Reset mid-window: `rst` high during CRIT with `sel`=2 → next edge `critical`=0, `sel`=0, state IDLE, no `timeout` pulse.
